run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_seq_pkg.sv | 26 ++
 rtl/sat_counter.sv | 28 ++
 rtl/run_sequencer.sv | 154 +++++++++++++++
 tb/tb_run_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: FSM states, DUT reset
// length, cycle counter width and the programs-per-batch decode.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DUT_RST = 3'd1,
        START   = 3'd2,
        GUARD   = 3'd3,
        WAIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DUT_RST_CYCLES = 2;
    localparam int CNT_W          = 16;

    // A NumProgs value of zero requests a full batch of four programs.
    function automatic logic [2:0] progs_target(input logic [1:0] num);
        if (num == 2'd0) begin
            return 3'd4;
        end else begin
            return {1'b0, num};
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-program cycle counter: loads one on the DutStart cycle, then counts up
// and sticks at all-ones so very long programs report the maximum value.
module sat_counter
    import run_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Load, saturating increment or hold the cycle count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= {{(W-1){1'b0}}, 1'b1};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Batch run sequencer: resets the processor under control, then starts each
// program in turn, timing it until Ack or an optional timeout.  All outputs
// are registered from the next-state decode, so none follow inputs directly.
module run_sequencer
    import run_seq_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [1:0]        NumProgs,
    input  logic [15:0]       TimeoutLimit,
    input  logic              Ack,
    output logic              DutReset,
    output logic              DutStart,
    output logic [1:0]        ProgIdx,
    output logic              Busy,
    output logic              Done,
    output logic              TimedOut,
    output logic [CNT_W-1:0]  LastCycles,
    output logic [2:0]        ProgsDone
);

    state_t             state_r;
    state_t             state_s;
    logic [1:0]         rst_cnt_r;
    logic [2:0]         target_r;
    logic [15:0]        timeout_r;
    logic [CNT_W-1:0]   count_s;
    logic               cnt_load_s;
    logic               cnt_inc_s;
    logic               accept_go_s;
    logic               prog_ack_s;
    logic               timeout_s;
    logic [2:0]         progs_next_s;

    sat_counter #(.W(CNT_W)) u_cycles (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (cnt_load_s),
        .inc   (cnt_inc_s),
        .count (count_s)
    );

    // Next-state decode plus counter controls and batch events.
    always_comb begin
        state_s      = state_r;
        cnt_load_s   = 1'b0;
        cnt_inc_s    = 1'b0;
        accept_go_s  = 1'b0;
        prog_ack_s   = 1'b0;
        timeout_s    = 1'b0;
        progs_next_s = ProgsDone + 3'd1;
        case (state_r)
            IDLE: begin
                if (Go) begin
                    accept_go_s = 1'b1;
                    state_s     = DUT_RST;
                end else begin
                    state_s = IDLE;
                end
            end
            DUT_RST: begin
                if (rst_cnt_r == 2'(DUT_RST_CYCLES - 1)) begin
                    state_s = START;
                end else begin
                    state_s = DUT_RST;
                end
            end
            START: begin
                cnt_load_s = 1'b1;
                state_s    = GUARD;
            end
            GUARD: begin
                // Ack may still be high from the previous program's halt.
                cnt_inc_s = 1'b1;
                state_s   = WAIT;
            end
            WAIT: begin
                if (Ack) begin
                    prog_ack_s = 1'b1;
                    if (progs_next_s == target_r) begin
                        state_s = DONE;
                    end else begin
                        state_s = START;
                    end
                end else begin
                    cnt_inc_s = 1'b1;
                    if ((timeout_r != 16'd0) && (count_s >= timeout_r)) begin
                        timeout_s = 1'b1;
                        state_s   = DONE;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, batch bookkeeping and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            rst_cnt_r  <= 2'd0;
            target_r   <= 3'd4;
            timeout_r  <= 16'd0;
            ProgIdx    <= 2'd0;
            ProgsDone  <= 3'd0;
            TimedOut   <= 1'b0;
            LastCycles <= {CNT_W{1'b0}};
            DutReset   <= 1'b1;
            DutStart   <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == DUT_RST) begin
                rst_cnt_r <= rst_cnt_r + 2'd1;
            end else begin
                rst_cnt_r <= 2'd0;
            end
            if (accept_go_s) begin
                target_r  <= progs_target(NumProgs);
                timeout_r <= TimeoutLimit;
                ProgIdx   <= 2'd0;
                ProgsDone <= 3'd0;
                TimedOut  <= 1'b0;
            end else if (prog_ack_s) begin
                LastCycles <= count_s;
                ProgsDone  <= progs_next_s;
                if (state_s == START) begin
                    ProgIdx <= ProgIdx + 2'd1;
                end else begin
                    ProgIdx <= ProgIdx;
                end
            end else if (timeout_s) begin
                TimedOut   <= 1'b1;
                LastCycles <= count_s;
            end else begin
                ProgIdx <= ProgIdx;
            end
            DutReset <= (state_s == IDLE) || (state_s == DUT_RST) || (state_s == DONE);
            DutStart <= (state_s == START);
            Busy     <= (state_s != IDLE);
            Done     <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: directed scenarios plus randomized
// batches compared against a per-program timing model.
module tb_run_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Go;
    logic [1:0]  NumProgs;
    logic [15:0] TimeoutLimit;
    logic        Ack;
    logic        DutReset;
    logic        DutStart;
    logic [1:0]  ProgIdx;
    logic        Busy;
    logic        Done;
    logic        TimedOut;
    logic [15:0] LastCycles;
    logic [2:0]  ProgsDone;

    int vectors     = 0;
    int miscompares = 0;

    // Observations gathered by drive_batch.
    int          obs_starts;
    int          obs_rst;
    int          obs_done;
    bit          obs_idx_ok;
    bit          obs_overlap;
    bit          obs_hung;
    bit          obs_idle_ok;
    logic [2:0]  obs_pd;
    logic [15:0] obs_lc;
    logic        obs_to;

    run_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Go           (Go),
        .NumProgs     (NumProgs),
        .TimeoutLimit (TimeoutLimit),
        .Ack          (Ack),
        .DutReset     (DutReset),
        .DutStart     (DutStart),
        .ProgIdx      (ProgIdx),
        .Busy         (Busy),
        .Done         (Done),
        .TimedOut     (TimedOut),
        .LastCycles   (LastCycles),
        .ProgsDone    (ProgsDone)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: each program acks at cycle max(d,2) after its start,
    // times out at cycle max(L,2) when L is nonzero; Ack wins a tie.
    task automatic model_batch(input logic [1:0] n, input logic [15:0] lim, input int d[4],
                               output int e_starts, output int e_pd, output int e_lc, output bit e_to);
        int total;
        int t;
        int a;
        bit stop;
        total = (n == 2'd0) ? 4 : int'(n);
        t = (lim == 16'd0) ? 32'h7fffffff : ((lim < 16'd2) ? 2 : int'(lim));
        e_starts = 0; e_pd = 0; e_lc = 0; e_to = 1'b0; stop = 1'b0;
        for (int p = 0; p < total; p++) begin
            if (!stop) begin
                e_starts++;
                a = (d[p] < 2) ? 2 : d[p];
                if (a <= t) begin
                    e_pd++;
                    e_lc = (a > 65535) ? 65535 : a;
                end else begin
                    e_to = 1'b1;
                    e_lc = t;
                    stop = 1'b1;
                end
            end
        end
    endtask

    // Launch one batch and act as the processor, acking program p at cycle d[p].
    task automatic drive_batch(input logic [1:0] n, input logic [15:0] lim, input int d[4],
                               input bit stale, input bit busy_go);
        int p;
        int k;
        int cyc;
        bit done_seen;
        obs_starts = 0; obs_rst = 0; obs_done = 0; obs_idx_ok = 1'b1;
        obs_overlap = 1'b0; obs_hung = 1'b0; obs_idle_ok = 1'b0;
        obs_pd = 3'd0; obs_lc = 16'd0; obs_to = 1'b0;
        p = -1; k = 0; cyc = 0; done_seen = 1'b0;
        @(negedge Clk);
        Go = 1'b1; NumProgs = n; TimeoutLimit = lim; Ack = 1'b0;
        @(negedge Clk);
        Go = 1'b0;
        while (!done_seen && cyc < 80000) begin
            if (DutReset && DutStart) obs_overlap = 1'b1;
            if (Busy && DutReset && !Done && obs_starts == 0) obs_rst++;
            if (DutStart) begin
                if (ProgIdx != obs_starts[1:0]) obs_idx_ok = 1'b0;
                obs_starts++; p++; k = 0;
            end else begin
                k++;
            end
            if (Done) begin
                obs_done++; done_seen = 1'b1;
                obs_pd = ProgsDone; obs_lc = LastCycles; obs_to = TimedOut;
            end
            if (p < 0 || done_seen) begin
                Ack = 1'b0;
            end else begin
                Ack = (stale && k < 2) || (k >= d[(p > 3) ? 3 : p]);
            end
            if (busy_go && !done_seen) begin
                Go = 1'($urandom_range(0, 1));
                NumProgs = 2'($urandom_range(0, 3));
                TimeoutLimit = 16'($urandom_range(1, 3));
            end else begin
                Go = 1'b0;
            end
            @(negedge Clk);
            cyc++;
        end
        Go = 1'b0; Ack = 1'b0;
        obs_hung = !done_seen;
        if (Done) obs_done++;
        obs_idle_ok = !Busy && !Done && DutReset && !DutStart &&
                      (ProgsDone == obs_pd) && (LastCycles == obs_lc) && (TimedOut == obs_to);
        if (obs_hung) $display("FAIL batch_bound: Done never seen within %0d cycles", cyc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Go = 1'b1; NumProgs = 2'd1; TimeoutLimit = 16'd0; Ack = 1'b0;
        repeat (3) @(negedge Clk);
        vectors++; if (DutReset !== 1'b1)    begin miscompares++; $display("FAIL rst_dutreset: got %b want 1", DutReset); end
        vectors++; if (DutStart !== 1'b0)    begin miscompares++; $display("FAIL rst_dutstart: got %b want 0", DutStart); end
        vectors++; if (Busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b want 0", Busy); end
        vectors++; if (Done !== 1'b0)        begin miscompares++; $display("FAIL rst_done: got %b want 0", Done); end
        vectors++; if (TimedOut !== 1'b0)    begin miscompares++; $display("FAIL rst_timedout: got %b want 0", TimedOut); end
        vectors++; if (ProgIdx !== 2'd0)     begin miscompares++; $display("FAIL rst_progidx: got %0d want 0", ProgIdx); end
        vectors++; if (ProgsDone !== 3'd0)   begin miscompares++; $display("FAIL rst_progsdone: got %0d want 0", ProgsDone); end
        vectors++; if (LastCycles !== 16'd0) begin miscompares++; $display("FAIL rst_lastcycles: got %0d want 0", LastCycles); end
        Reset = 1'b0; Go = 1'b0;
        @(negedge Clk);
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_go_dropped: busy got %b want 0", Busy); end
    endtask

    task automatic test_single();
        int d[4];
        d = '{10, 0, 0, 0};
        drive_batch(2'd1, 16'd0, d, 1'b0, 1'b0);
        vectors++; if (obs_rst != 2)         begin miscompares++; $display("FAIL single_dutrst_len: got %0d want 2", obs_rst); end
        vectors++; if (obs_starts != 1)      begin miscompares++; $display("FAIL single_starts: got %0d want 1", obs_starts); end
        vectors++; if (obs_lc !== 16'd10)    begin miscompares++; $display("FAIL single_lastcycles: got %0d want 10", obs_lc); end
        vectors++; if (obs_pd !== 3'd1)      begin miscompares++; $display("FAIL single_progsdone: got %0d want 1", obs_pd); end
        vectors++; if (obs_to !== 1'b0)      begin miscompares++; $display("FAIL single_timedout: got %b want 0", obs_to); end
        vectors++; if (obs_done != 1)        begin miscompares++; $display("FAIL single_done_pulse: got %0d want 1", obs_done); end
        vectors++; if (!obs_idle_ok)         begin miscompares++; $display("FAIL single_idle_hold: got 0 want 1"); end
        vectors++; if (obs_overlap)          begin miscompares++; $display("FAIL single_overlap: got 1 want 0"); end
    endtask

    task automatic test_four_stale();
        int d[4];
        d = '{5, 5, 5, 5};
        drive_batch(2'd0, 16'd0, d, 1'b1, 1'b0);
        vectors++; if (obs_starts != 4)      begin miscompares++; $display("FAIL stale_starts: got %0d want 4", obs_starts); end
        vectors++; if (!obs_idx_ok)          begin miscompares++; $display("FAIL stale_progidx: got 0 want 1"); end
        vectors++; if (obs_pd !== 3'd4)      begin miscompares++; $display("FAIL stale_progsdone: got %0d want 4", obs_pd); end
        vectors++; if (obs_lc !== 16'd5)     begin miscompares++; $display("FAIL stale_lastcycles: got %0d want 5", obs_lc); end
        vectors++; if (ProgIdx !== 2'd3)     begin miscompares++; $display("FAIL stale_lastidx: got %0d want 3", ProgIdx); end
    endtask

    task automatic test_timeout();
        int d[4];
        d = '{100000, 100000, 100000, 100000};
        drive_batch(2'd2, 16'd20, d, 1'b0, 1'b0);
        vectors++; if (obs_to !== 1'b1)      begin miscompares++; $display("FAIL timeout_flag: got %b want 1", obs_to); end
        vectors++; if (obs_lc !== 16'd20)    begin miscompares++; $display("FAIL timeout_lastcycles: got %0d want 20", obs_lc); end
        vectors++; if (obs_pd !== 3'd0)      begin miscompares++; $display("FAIL timeout_progsdone: got %0d want 0", obs_pd); end
        vectors++; if (obs_starts != 1)      begin miscompares++; $display("FAIL timeout_starts: got %0d want 1", obs_starts); end
        vectors++; if (obs_done != 1)        begin miscompares++; $display("FAIL timeout_done_pulse: got %0d want 1", obs_done); end
    endtask

    task automatic test_ack_at_limit();
        int d[4];
        d = '{20, 0, 0, 0};
        drive_batch(2'd1, 16'd20, d, 1'b0, 1'b0);
        vectors++; if (obs_to !== 1'b0)      begin miscompares++; $display("FAIL tie_timedout: got %b want 0", obs_to); end
        vectors++; if (obs_pd !== 3'd1)      begin miscompares++; $display("FAIL tie_progsdone: got %0d want 1", obs_pd); end
        vectors++; if (obs_lc !== 16'd20)    begin miscompares++; $display("FAIL tie_lastcycles: got %0d want 20", obs_lc); end
    endtask

    task automatic test_reset_mid();
        int starts;
        int k;
        int cyc;
        starts = 0; k = 0; cyc = 0;
        @(negedge Clk);
        Go = 1'b1; NumProgs = 2'd3; TimeoutLimit = 16'd0; Ack = 1'b0;
        @(negedge Clk);
        Go = 1'b0;
        while (starts < 2 && cyc < 200) begin
            if (DutStart) begin starts++; k = 0; end else k++;
            Ack = (starts == 1) && (k >= 3);
            Go = (starts == 1) && (k == 1);
            NumProgs = 2'd1;
            @(negedge Clk);
            cyc++;
        end
        Go = 1'b0; Ack = 1'b0;
        vectors++; if (starts != 2) begin miscompares++; $display("FAIL mid_second_start: got %0d starts want 2", starts); end
        repeat (3) @(negedge Clk);
        vectors++; if (ProgsDone !== 3'd1)   begin miscompares++; $display("FAIL mid_busy_go_ignored: progsdone %0d want 1", ProgsDone); end
        vectors++; if (LastCycles !== 16'd3) begin miscompares++; $display("FAIL mid_lastcycles: got %0d want 3", LastCycles); end
        vectors++; if (ProgIdx !== 2'd1)     begin miscompares++; $display("FAIL mid_progidx: got %0d want 1", ProgIdx); end
        Reset = 1'b1; Go = 1'b1;
        @(negedge Clk);
        vectors++; if (Busy !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
        vectors++; if (DutReset !== 1'b1)    begin miscompares++; $display("FAIL mid_rst_dutreset: got %b want 1", DutReset); end
        vectors++; if (ProgsDone !== 3'd0)   begin miscompares++; $display("FAIL mid_rst_progsdone: got %0d want 0", ProgsDone); end
        vectors++; if (ProgIdx !== 2'd0)     begin miscompares++; $display("FAIL mid_rst_progidx: got %0d want 0", ProgIdx); end
        vectors++; if (LastCycles !== 16'd0) begin miscompares++; $display("FAIL mid_rst_lastcycles: got %0d want 0", LastCycles); end
        Reset = 1'b0; Go = 1'b0;
        @(negedge Clk);
        vectors++; if (Busy !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_go_dropped: busy %b want 0", Busy); end
    endtask

    task automatic test_random();
        int d[4];
        logic [1:0]  n;
        logic [15:0] lim;
        bit stale;
        int e_starts;
        int e_pd;
        int e_lc;
        bit e_to;
        for (int b = 0; b < 12; b++) begin
            n = 2'($urandom_range(0, 3));
            lim = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 30);
            stale = 1'($urandom_range(0, 1));
            model_batch(n, lim, d, e_starts, e_pd, e_lc, e_to);
            drive_batch(n, lim, d, stale, 1'b1);
            vectors++; if (obs_starts != e_starts) begin miscompares++; $display("FAIL rand%0d_starts: got %0d want %0d", b, obs_starts, e_starts); end
            vectors++; if (int'(obs_pd) != e_pd)   begin miscompares++; $display("FAIL rand%0d_progsdone: got %0d want %0d", b, obs_pd, e_pd); end
            vectors++; if (int'(obs_lc) != e_lc)   begin miscompares++; $display("FAIL rand%0d_lastcycles: got %0d want %0d", b, obs_lc, e_lc); end
            vectors++; if (obs_to !== e_to)        begin miscompares++; $display("FAIL rand%0d_timedout: got %b want %b", b, obs_to, e_to); end
            vectors++; if (obs_rst != 2 || obs_done != 1 || !obs_idx_ok || obs_overlap || !obs_idle_ok)
                begin miscompares++; $display("FAIL rand%0d_protocol: rst %0d done %0d idx %b ovl %b idle %b want 2 1 1 0 1",
                                              b, obs_rst, obs_done, obs_idx_ok, obs_overlap, obs_idle_ok); end
        end
    endtask

    task automatic test_saturate();
        int d[4];
        d = '{70000, 0, 0, 0};
        drive_batch(2'd1, 16'd0, d, 1'b0, 1'b0);
        vectors++; if (obs_to !== 1'b0)        begin miscompares++; $display("FAIL sat_timedout: got %b want 0", obs_to); end
        vectors++; if (obs_lc !== 16'hFFFF)    begin miscompares++; $display("FAIL sat_lastcycles: got %h want ffff", obs_lc); end
        vectors++; if (obs_pd !== 3'd1)        begin miscompares++; $display("FAIL sat_progsdone: got %0d want 1", obs_pd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_stale();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
